shift_ctrl: RTL
===============

Name: shift_ctrl

Overview:
Frame sequencer for the serial-in shift-register datapath. It accepts a parallel word on a start handshake and drives it bit-serially, MSB first, with a shift enable, for exactly WIDTH clocks. It simultaneously captures WIDTH returned serial bits into a parallel result and pulses done. It sits between a parallel producer/consumer and the 6-bit serial shift chain.

Parameters:
WIDTH, 6, frame length in bits; legal range 2..32
IDLE_FILL, 1'b0, value driven on so while not shifting

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  request to send a frame; sampled only in IDLE
din  input  WIDTH  parallel word to serialize; sampled on the accepting edge
si  input  1  serial return bit from the shift chain; sampled on every SHIFT edge
so  output  1  serial data to the shift chain si
sen  output  1  shift enable to the chain; high only in SHIFT
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle completion pulse
dout  output  WIDTH  captured word; held until the next completion

Behaviour:
- Reset is asynchronous and active-high, and uses one clock:
  - state=IDLE, tx=0, rx=0, cnt=0
  - so=IDLE_FILL, sen=0, busy=0, done=0, dout=0
  - Takes effect immediately, mid-frame included. The partial frame is discarded and dout is cleared.
- Counter: cnt is $clog2(WIDTH) bits wide and counts 0..WIDTH-1. It never wraps past WIDTH-1.
- States:
  - IDLE:
    - so=IDLE_FILL, sen=0, busy=0.
    - start=1 at edge k: tx<=din, cnt<=0, go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT:
    - so=tx[WIDTH-1] (combinational from tx), sen=1, busy=1.
    - Each edge: tx<=tx<<1 with 0 filled in, rx<={rx[WIDTH-2:0],si}, cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: dout<={rx[WIDTH-2:0],si}, cnt<=0, go to DONE.
  - DONE:
    - done=1, busy=1, sen=0, so=IDLE_FILL.
    - Next edge: unconditionally go to IDLE.
- Timing for start accepted at edge k:
  - so carries din[WIDTH-1]..din[0] in the cycles following edges k..k+WIDTH-1.
  - sen is high for exactly WIDTH cycles.
  - done is high in the cycle after edge k+WIDTH; dout updates at that same edge.
- Start rules:
  - start is ignored in SHIFT and DONE; there is no queuing.
  - start held high continuously gives back-to-back frames with exactly one IDLE cycle between DONE and the next SHIFT.
- din changes after the accepting edge have no effect on the frame in flight.
- X on si propagates into rx and dout only. It never affects control state.
- done is never high in two consecutive cycles.
- sen and done are never high together.

Optional Feature:
LSB_FIRST_EN
- Defined:
  - so=tx[0]; tx shifts right.
  - rx<={si,rx[WIDTH-1:1]}; on the final edge dout<={si,rx[WIDTH-1:1]}.
  - Bit order on the wire is din[0] first. A loopback frame still returns dout==din.
- Undefined: MSB-first exactly as in Behaviour. Timing, handshake and reset are identical in both builds.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs go to reset values immediately (so=0, sen=0, busy=0, done=0, dout=0); state remains IDLE after release.
- Single frame with si looped to so: din=6'b101101, start pulsed one cycle -> so sequence 1,0,1,1,0,1 with sen high 6 cycles, then done high 1 cycle, dout=6'b101101, busy low one cycle later.
- Independent si: din=6'b000000, si driven 1,0,1,0,1,0 on successive SHIFT cycles -> dout=6'b101010, so stays 0 throughout.
- Start while busy: start pulse with din=6'b111111 at the third SHIFT cycle of a din=6'b100001 frame -> ignored; only the 6'b100001 bits appear on so, one done pulse.
- Back-to-back: start held high with din=6'b110011 -> frames separated by exactly one IDLE cycle (DONE, IDLE, SHIFT); done pulses are 8 cycles apart.
- Reset mid-frame: rst asserted during the fourth SHIFT cycle -> sen, busy and dout drop to 0 immediately; no done pulse. A new start after release sends a full 6-bit frame.

Source files
------------

// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if: handshake and serial bus between a parallel producer/consumer
// and the shift_ctrl frame sequencer.
//   start : request to send a frame (producer -> sequencer)
//   din   : parallel word to serialize (producer -> sequencer)
//   si    : serial return bit from the shift chain (chain -> sequencer)
//   so    : serial data to the shift chain (sequencer -> chain)
//   sen   : shift enable to the chain
//   busy  : frame in progress (SHIFT or DONE)
//   done  : one-cycle completion pulse
//   dout  : captured word, held until the next completion
// Modports: master = producer/consumer side, slave = sequencer side.
interface shift_ctrl_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             si;
  logic             so;
  logic             sen;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start, din, si,
    input  so, sen, busy, done, dout
  );

  modport slave (
    input  start, din, si,
    output so, sen, busy, done, dout
  );
endinterface

// File: rtl/shift_ctrl.sv
// shift_ctrl: frame sequencer for the serial shift chain. A parallel word taken
// on start is driven bit-serially on so with sen high for exactly WIDTH clocks,
// while WIDTH returned bits on si are captured into dout; done then pulses once.
// Ports:
//   i_clk : system clock, all state updates on posedge
//   i_rst : asynchronous active-high reset
//   bus   : shift_ctrl_if.slave (start, din, si in; so, sen, busy, done, dout out)
// Parameters: WIDTH (2..32) frame length, IDLE_FILL level on so when not shifting.
// Build option: define LSB_FIRST_EN to send/receive din[0] first instead of MSB first.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, so = IDLE_FILL
// S_SHIFT | driving tx out on so, sampling si into rx
// S_DONE  | one-cycle done pulse, dout holds the new word
module shift_ctrl #(
  parameter int   WIDTH     = 6,
  parameter logic IDLE_FILL = 1'b0
) (
  input logic         i_clk,
  input logic         i_rst,
  shift_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_dout;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic             w_tx_bit;
  logic [WIDTH-1:0] w_tx_shift;
  logic [WIDTH-1:0] w_rx_shift;
  logic             w_so;
  logic             w_sen;
  logic             w_busy;
  logic             w_done;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef LSB_FIRST_EN
  assign w_tx_bit   = r_tx[0];
  assign w_tx_shift = {1'b0, r_tx[WIDTH-1:1]};
  assign w_rx_shift = {bus.si, r_rx[WIDTH-1:1]};
`else
  assign w_tx_bit   = r_tx[WIDTH-1];
  assign w_tx_shift = {r_tx[WIDTH-2:0], 1'b0};
  assign w_rx_shift = {r_rx[WIDTH-2:0], bus.si};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // si only reaches the datapath below, so an unknown return bit can never
  // disturb the state sequence.
  always_comb begin
    w_next = r_state;
    w_so   = IDLE_FILL;
    w_sen  = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_so   = w_tx_bit;
        w_sen  = 1'b1;
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_tx  <= bus.din;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_tx <= w_tx_shift;
          r_rx <= w_rx_shift;
          if (w_last) begin
            // final bit goes straight into dout in the same edge
            r_dout <= w_rx_shift;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.so   = w_so;
  assign bus.sen  = w_sen;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.dout = r_dout;
endmodule
